medidor_distancia: RTL
======================

// Module: medidor_distancia
// PURPOSE
//  Drives an HC-SR04-style ultrasonic ranger and converts its echo pulse width to
//  centimetres. It sits directly upstream of the motor control stage and feeds that
//  stage's 9-bit distancia input. It re-measures periodically and holds the last
//  result between measurements.
// PARAMETERS
//  TRIG_CYCLES     500        trig high time in clk cycles (10 us @ 50 MHz)
//  TICKS_PER_CM    2900       clk cycles of echo per centimetre (58 us @ 50 MHz)
//  TIMEOUT_CYCLES  1_500_000  max cycles in WAIT_RISE or MEASURE (30 ms)
//  PERIOD_CYCLES   3_000_000  idle cycles between measurements (60 ms)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  echo       in   1  sensor echo, asynchronous to clk
//  trig       out  1  sensor trigger pulse
//  distancia  out  9  last measured distance, cm, unsigned, saturated at 511
//  valid      out  1  one-cycle pulse when distancia/timeout are updated
//  timeout    out  1  high while the last measurement ended by timeout
// BEHAVIOUR
//  Reset (async, any state):
//   - FSM goes to IDLE; trig=0, distancia=0, valid=0, timeout=0; all counters cleared.
//   - distancia=0 on reset is deliberate: downstream treats <15 cm as obstacle, so the
//     robot is held stopped until the first valid measurement.
//  echo passes through a 2-FF synchronizer, then an edge detector (rise/fall = 1-cycle pulses).
//  FSM states; one cycle counter is cleared on every state entry:
//   - IDLE: trig=0. Leaves for TRIG after PERIOD_CYCLES cycles.
//   - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then goes to WAIT_RISE.
//   - WAIT_RISE: on synced rising edge, go to MEASURE.
//     If the counter reaches TIMEOUT_CYCLES first, go to DONE with the timeout result.
//     An echo already high on entry (no edge) is ignored and ends in timeout.
//   - MEASURE: prescaler counts 0..TICKS_PER_CM-1; on wrap, cm_acc increments and
//     saturates at 511 (no wrap-around). On synced falling edge, go to DONE with cm_acc
//     (floor division). If the counter reaches TIMEOUT_CYCLES first, take the timeout result.
//   - DONE (1 cycle): register the result and pulse valid=1, then go to IDLE.
//  Results written in DONE:
//   - Normal: distancia=cm_acc, timeout=0.
//   - Timeout: distancia=9'd511, timeout=1.
//  Output holding:
//   - distancia and timeout change only in DONE or on reset; they hold otherwise.
//  Latency: valid asserts 3 cycles after echo falls at the pin (2 sync + 1 DONE).
//  Width of cm_acc: 9 bits. Counter widths are sized with $clog2 of the largest
//   parameter (TIMEOUT_CYCLES or PERIOD_CYCLES).
//  Echo edges outside WAIT_RISE/MEASURE are ignored. A 1-cycle echo pulse yields 0 cm.
//  Reset mid-measurement: trig drops immediately (async), the measurement is discarded,
//   and the next cycle starts a fresh IDLE period.
// STRUCTURE
//  Shared package/header medidor_pkg:
//   - FSM state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, DONE)
//   - DIST_MAX = 9'd511
//   - DIST_RESET = 9'd0
//  One sub-module: sync_edge (2-FF synchronizer plus rise/fall pulse outputs,
//   async active-high reset to 0). It is reused for the line-follower inputs.
//  The remainder (FSM, cycle counter, cm prescaler, output registers) stays flat.
// TESTING (sim params: TRIG_CYCLES=4, TICKS_PER_CM=10, TIMEOUT_CYCLES=6000, PERIOD_CYCLES=50)
//  1 Reset: rst=1 -> trig=0, distancia=0, valid=0, timeout=0; after release trig
//    rises after 50 clk and stays high exactly 4 clk.
//  2 Echo high 125 clk after trig -> distancia=12, timeout=0, one valid pulse
//    3 clk after echo falls; value holds through the next IDLE.
//  3 Threshold: echo 150 clk -> 15; echo 149 clk -> 14 (floor, matches downstream >=15 compare).
//  4 Saturation: echo high 5500 clk -> distancia=511, timeout=0.
//    No echo at all -> after 6000 clk in WAIT_RISE: distancia=511, timeout=1, valid pulse.
//  5 Reset asserted mid-MEASURE -> trig=0 and distancia=0 immediately; after release,
//    an 80-clk echo gives 8 with no residue from the aborted measurement.
//  6 Echo held high before trig ends -> no rise detected -> timeout result.
//    The next cycle with a normal 40-clk echo gives distancia=4 and timeout cleared.

Source files
------------

// File: rtl/medidor_pkg.sv
// Shared definitions for the ultrasonic distance meter: FSM encoding and
// distance constants used by the ranger and by the motor-control stage.
package medidor_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [8:0] DIST_MAX   = 9'd511;
    localparam logic [8:0] DIST_RESET = 9'd0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer with one-cycle rise/fall pulses, one lane per input bit.
// Shared by the echo input and the line-follower sensors.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/medidor_distancia.sv
// HC-SR04 driver: periodic trigger, echo width measured in whole centimetres,
// last result held between measurements for the motor-control stage.
module medidor_distancia
    import medidor_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TICKS_PER_CM   = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned PERIOD_CYCLES  = 3_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distancia,
    output logic       valid,
    output logic       timeout
);

    localparam int unsigned CNT_MAX = max_u(TIMEOUT_CYCLES, PERIOD_CYCLES);
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam int          PRE_W   = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICKS_PER_CM - 1);

    // The cycle that sees the rising edge already counts as one echo tick,
    // so N echo cycles yield floor(N / TICKS_PER_CM).
    localparam logic [PRE_W-1:0] PRE_START = (TICKS_PER_CM > 1) ? PRE_W'(1) : '0;
    localparam logic [8:0]       CM_START  = (TICKS_PER_CM > 1) ? 9'd0 : 9'd1;

    logic             echo_rise;
    logic             echo_fall;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] presc;
    logic [8:0]       cm_acc;

    sync_edge #(.W(1)) u_echo_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (echo),
        .rise (echo_rise),
        .fall (echo_fall)
    );

    // Results are loaded on the edge into DONE, so valid is high exactly
    // while the FSM sits in DONE and distancia is already stable with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            presc     <= '0;
            cm_acc    <= '0;
            trig      <= 1'b0;
            distancia <= DIST_RESET;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            cnt   <= cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (cnt == PERIOD_LAST) begin
                        state <= ST_TRIG;
                        cnt   <= '0;
                        trig  <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state <= ST_WAIT_RISE;
                        cnt   <= '0;
                        trig  <= 1'b0;
                    end
                end
                ST_WAIT_RISE: begin
                    if (echo_rise) begin
                        state  <= ST_MEASURE;
                        cnt    <= '0;
                        presc  <= PRE_START;
                        cm_acc <= CM_START;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= ST_DONE;
                        cnt       <= '0;
                        distancia <= DIST_MAX;
                        timeout   <= 1'b1;
                        valid     <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (echo_fall) begin
                        state     <= ST_DONE;
                        cnt       <= '0;
                        distancia <= cm_acc;
                        timeout   <= 1'b0;
                        valid     <= 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= ST_DONE;
                        cnt       <= '0;
                        distancia <= DIST_MAX;
                        timeout   <= 1'b1;
                        valid     <= 1'b1;
                    end else if (presc == PRE_LAST) begin
                        presc <= '0;
                        if (cm_acc != DIST_MAX)
                            cm_acc <= cm_acc + 9'd1;
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    trig  <= 1'b0;
                end
            endcase
        end
    end

endmodule
